// File: rtl/mul_ci_pkg.sv
// Shared opcode and FSM encodings for the sequential multiply/MAC custom instruction.
package mul_ci_pkg;

  typedef enum logic [2:0] {
    OP_WR_A  = 3'd0,
    OP_WR_B  = 3'd1,
    OP_MUL_S = 3'd2,
    OP_MUL_U = 3'd3,
    OP_MAC_S = 3'd4,
    OP_RD_HI = 3'd5,
    OP_RD_LO = 3'd6,
    OP_CLR   = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/mul_seq_core.sv
// Unsigned radix-2 shift-add multiplier: one multiplier bit per enabled cycle,
// WIDTH iterations, full 2*WIDTH-bit product.
module mul_seq_core #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand_r;
  // Upper half accumulates partial sums, lower half shifts the multiplier out.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;

  assign sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand_r : '0)};

  // Operand capture on start, then one add-and-shift step per enabled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run     <= 1'b0;
      cnt     <= '0;
      mcand_r <= '0;
      prod    <= '0;
    end else if (clk_en) begin
      if (start && !run) begin
        run     <= 1'b1;
        cnt     <= '0;
        mcand_r <= mcand;
        prod    <= {{WIDTH{1'b0}}, mplier};
      end else if (run) begin
        prod <= {sum, prod[WIDTH-1:1]};
        if (cnt == LAST) begin
          run <= 1'b0;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign busy    = run;
  // High during the final iteration; the finished product is in prod after this edge.
  assign done    = run && (cnt == LAST);
  assign product = prod;

endmodule

// File: rtl/mul_seq_mac_ci.sv
// Sequential multiply / multiply-accumulate custom instruction. Sign handling
// and accumulation wrap an unsigned shift-add core.
module mul_seq_mac_ci
  import mul_ci_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MAC_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [2:0]       n,
  input  logic [WIDTH-1:0] dataa,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  // Magnitude of an operand; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  // Two's-complement sign restore of the unsigned product, modulo 2^(2W).
  function automatic logic signed [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic neg);
    return neg ? $signed(~p + 1'b1) : $signed(p);
  endfunction

  state_e state, state_nxt;
  opcode_e op;

  logic [WIDTH-1:0]          a_reg, b_reg;
  logic signed [2*WIDTH-1:0] p_reg;
  logic signed [2*WIDTH-1:0] p_new;
  logic                      neg, mac, rd_pend, rd_hi;
  logic                      accept, is_mul, sgn_op;
  logic                      core_start, core_busy, core_done;
  logic [2*WIDTH-1:0]        core_product;

  assign op     = opcode_e'(n);
  assign busy   = (state != ST_IDLE) || core_busy;
  assign accept = start && clk_en && !busy && !reset;
  assign is_mul = (op == OP_MUL_S) || (op == OP_MUL_U) || (op == OP_MAC_S);
  assign sgn_op = (op != OP_MUL_U);
  assign core_start = accept && is_mul;

  assign p_new = mac ? (p_reg + apply_sign(core_product, neg)) : apply_sign(core_product, neg);

  mul_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .start   (core_start),
    .mcand   (magnitude(a_reg, sgn_op)),
    .mplier  (magnitude(b_reg, sgn_op)),
    .busy    (core_busy),
    .done    (core_done),
    .product (core_product)
  );

  // FSM state register; frozen while clk_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  // Next state plus the done/result strobe for every instruction class.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    result    = '0;
    case (state)
      ST_IDLE: if (core_start) state_nxt = ST_CALC;
      ST_CALC: if (core_done)  state_nxt = ST_FIN;
      ST_FIN: begin
        state_nxt = ST_IDLE;
        if (clk_en) begin
          done   = 1'b1;
          result = p_new[WIDTH-1:0];
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rd_pend && clk_en) begin
      done   = 1'b1;
      result = rd_hi ? p_reg[2*WIDTH-1:WIDTH] : p_reg[WIDTH-1:0];
    end
    if (accept && ((op == OP_WR_A) || (op == OP_WR_B) || (op == OP_CLR))) begin
      done = 1'b1;
    end
  end

  // Architectural registers, read request flag and latched multiply mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      p_reg   <= '0;
      neg     <= 1'b0;
      mac     <= 1'b0;
      rd_pend <= 1'b0;
      rd_hi   <= 1'b0;
    end else if (clk_en) begin
      rd_pend <= 1'b0;
      if (accept) begin
        case (op)
          OP_WR_A:  a_reg <= dataa;
          OP_WR_B:  b_reg <= dataa;
          OP_CLR:   p_reg <= '0;
          OP_RD_HI: begin rd_pend <= 1'b1; rd_hi <= 1'b1; end
          OP_RD_LO: begin rd_pend <= 1'b1; rd_hi <= 1'b0; end
          default: begin
            neg <= sgn_op && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
            mac <= (op == OP_MAC_S) && (MAC_EN != 0);
          end
        endcase
      end
      if (state == ST_FIN) p_reg <= p_new;
    end
  end

endmodule
